// File: rtl/fifo_read_streamer_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the streamer.
interface fifo_read_streamer_if #(
  parameter int DW = 16
);
  logic          fifo_empty_flag;
  logic [DW-1:0] fifo_data_output;
  logic          fifo_underflow_flag;
  logic          fifo_read_enable;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  // streamer side
  modport master (
    input  fifo_empty_flag, fifo_data_output, fifo_underflow_flag, out_ready,
    output fifo_read_enable, out_valid, out_data
  );

  // FIFO + downstream side
  modport slave (
    output fifo_empty_flag, fifo_data_output, fifo_underflow_flag, out_ready,
    input  fifo_read_enable, out_valid, out_data
  );
endinterface

// File: rtl/fifo_read_streamer.sv
// Drains a registered-read FIFO into a valid/ready stream through a 2-slot
// skid buffer. Reads are credited against slot occupancy plus the word in
// flight, so one word per cycle is sustained and nothing is ever dropped.
module fifo_read_streamer #(
  parameter int FIFO_DATA_WIDTH = 16,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  fifo_read_streamer_if.master   bus,
  output logic [COUNT_WIDTH-1:0] words_delivered,
  output logic                   underflow_error
);

  // state encoding doubles as the occupancy count
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t                                state, state_d;
  logic                                  inflight;
  logic                                  head, tail;
  logic [1:0][FIFO_DATA_WIDTH-1:0]       slots;
  logic                                  pop, capture;
  logic [2:0]                            used;

  assign pop     = bus.out_valid & bus.out_ready;
  assign capture = inflight;
  assign used    = {1'b0, state} + {2'b0, inflight};

  // a slot freed by this cycle's pop can be re-credited immediately;
  // reset_n gates the request so nothing is read while held in reset
  assign bus.fifo_read_enable = reset_n & enable & ~bus.fifo_empty_flag &
                                (used < (3'd2 + {2'b0, pop}));
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = slots[head];

  // occupancy FSM next-state
  always_comb begin
    state_d = state;
    unique case (state)
      EMPTY: if (capture) state_d = ONE;
      ONE: begin
        if (capture && !pop)      state_d = TWO;
        else if (pop && !capture) state_d = EMPTY;
      end
      TWO:     if (pop && !capture) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // control state, pointers, counter and sticky error
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= EMPTY;
      inflight        <= 1'b0;
      head            <= 1'b0;
      tail            <= 1'b0;
      words_delivered <= '0;
      underflow_error <= 1'b0;
    end else begin
      state    <= state_d;
      inflight <= bus.fifo_read_enable;
      if (capture) tail <= ~tail;
      if (pop) begin
        head            <= ~head;
        words_delivered <= words_delivered + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (bus.fifo_underflow_flag) underflow_error <= 1'b1;
    end
  end

  // landing slots: datapath only, contents are don't-care until captured
  always_ff @(posedge clk) begin
    if (capture) slots[tail] <= bus.fifo_data_output;
  end

  // credit rule must keep a full buffer from ever receiving a word it cannot pop
  assert property (@(posedge clk) disable iff (!reset_n)
                   !(state == TWO && capture && !pop));

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Directed bench: behavioural registered-read FIFO feeding two streamers
// (16-bit and 3-bit word counters) driven by identical stimulus.
module tb_fifo_read_streamer;

  logic clk = 1'b0;
  logic reset_n, fifo_rst_n, enable, out_ready, wr_en, force_uf;
  logic [15:0] wr_data;
  logic [15:0] words16;
  logic [2:0]  words3;
  logic        uerr16, uerr3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_read_streamer_if #(.DW(16)) bus16 ();
  fifo_read_streamer_if #(.DW(16)) bus3 ();

  // FIFO model: one-cycle registered read, empty follows pointers
  logic [15:0] mem [0:63];
  logic [5:0]  wp, rp;
  logic [15:0] rdata;
  logic        fifo_uf;

  always @(posedge clk) begin
    if (!fifo_rst_n) begin
      wp <= '0; rp <= '0; fifo_uf <= 1'b0;
    end else begin
      if (wr_en) begin mem[wp] <= wr_data; wp <= wp + 6'd1; end
      fifo_uf <= bus16.fifo_read_enable && (wp == rp);
      if (bus16.fifo_read_enable && (wp != rp)) begin
        rdata <= mem[rp]; rp <= rp + 6'd1;
      end
    end
  end

  assign bus16.fifo_empty_flag     = (wp == rp);
  assign bus16.fifo_data_output    = rdata;
  assign bus16.fifo_underflow_flag = fifo_uf | force_uf;
  assign bus16.out_ready           = out_ready;
  assign bus3.fifo_empty_flag      = bus16.fifo_empty_flag;
  assign bus3.fifo_data_output     = bus16.fifo_data_output;
  assign bus3.fifo_underflow_flag  = bus16.fifo_underflow_flag;
  assign bus3.out_ready            = out_ready;

  fifo_read_streamer #(.FIFO_DATA_WIDTH(16), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus16),
    .words_delivered(words16), .underflow_error(uerr16)
  );

  fifo_read_streamer #(.FIFO_DATA_WIDTH(16), .COUNT_WIDTH(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus3),
    .words_delivered(words3), .underflow_error(uerr3)
  );

  // received-word log
  logic [15:0] rx [$];
  always @(posedge clk)
    if (reset_n && bus16.out_valid && out_ready) rx.push_back(bus16.out_data);

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_assert++;
    assert (got_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; fifo_rst_n = 1'b0;
    tick; tick;
    reset_n = 1'b1; fifo_rst_n = 1'b1;
    #1;
    chk("rst_words", 32'(words16), 0);
    chk("rst_valid", 32'(bus16.out_valid), 0);
    chk("rst_uerr",  32'(uerr16), 0);
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = 16'(base + i); tick;
    end
    wr_en = 1'b0;
  endtask

  task automatic chk_rx(input string tag, input int n, input int base);
    chk({tag, "_cnt"}, 32'(rx.size()), 32'(n));
    for (int i = 0; i < n && i < rx.size(); i++)
      chk({tag, "_data"}, 32'(rx[i]), 32'(base + i));
  endtask

  initial begin
    automatic logic [11:0] rd_h, ov_h;
    automatic int rdc, bad;

    reset_n = 1'b0; fifo_rst_n = 1'b0; enable = 1'b1; out_ready = 1'b0;
    wr_en = 1'b0; wr_data = '0; force_uf = 1'b0;

    // reset with FIFO holding 3 words: no reads, outputs idle
    tick;
    fifo_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 16'(16'h11 + i); #1;
      if (bus16.fifo_read_enable !== 1'b0 || bus16.out_valid !== 1'b0) bad++;
      tick;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (bus16.fifo_read_enable !== 1'b0 || bus16.out_valid !== 1'b0) bad++;
      tick;
    end
    chk("rst_idle", 32'(bad), 0);
    chk("rst_words0", 32'(words16), 0);
    chk("rst_uerr0", 32'(uerr16), 0);
    reset_n = 1'b1; #1;
    chk("first_read", 32'(bus16.fifo_read_enable), 1);
    out_ready = 1'b1;
    repeat (6) tick;
    chk_rx("rst_drain", 3, 16'h11);

    // full throughput, 8 words
    do_reset;
    enable = 1'b0; fill(8, 1);
    rx.delete(); out_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1; rd_h[i] = bus16.fifo_read_enable; ov_h[i] = bus16.out_valid; tick;
    end
    chk("tp_reads", 32'(rd_h), 32'h0FF);
    chk("tp_valid", 32'(ov_h), 32'h3FC);
    chk_rx("tp", 8, 1);
    chk("tp_words", 32'(words16), 8);

    // backpressure: 2 reads, first word held
    do_reset;
    enable = 1'b0; out_ready = 1'b0; fill(8, 1);
    rx.delete(); enable = 1'b1; rdc = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1; rdc += int'(bus16.fifo_read_enable);
      if (bus16.out_valid && bus16.out_data !== 16'h1) bad++;
      tick;
    end
    chk("bp_reads", 32'(rdc), 2);
    chk("bp_valid", 32'(bus16.out_valid), 1);
    chk("bp_data", 32'(bus16.out_data), 1);
    chk("bp_hold", 32'(bad), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1; ov_h[i] = bus16.out_valid; tick;
    end
    chk("bp_nogap", 32'(ov_h[8:0]), 32'h0FF);
    chk_rx("bp", 8, 1);

    // enable dropped after 3 reads
    do_reset;
    enable = 1'b0; out_ready = 1'b1; fill(8, 1);
    rx.delete(); enable = 1'b1; rdc = 0;
    for (int i = 0; i < 3; i++) begin
      #1; rdc += int'(bus16.fifo_read_enable); tick;
    end
    chk("en_reads3", 32'(rdc), 3);
    enable = 1'b0; rdc = 0;
    for (int i = 0; i < 6; i++) begin
      #1; rdc += int'(bus16.fifo_read_enable); tick;
    end
    chk("en_noreads", 32'(rdc), 0);
    chk("en_idle", 32'(bus16.out_valid), 0);
    chk_rx("en_part", 3, 1);
    enable = 1'b1;
    repeat (12) tick;
    chk_rx("en_resume", 8, 1);

    // sticky underflow
    chk("uf_pre", 32'(uerr16), 0);
    force_uf = 1'b1; tick; force_uf = 1'b0; #1;
    chk("uf_set", 32'(uerr16), 1);
    repeat (5) tick;
    chk("uf_sticky", 32'(uerr16), 1);
    do_reset;
    chk("uf_clr", 32'(uerr16), 0);

    // 3-bit counter wrap over 9 words
    enable = 1'b0; out_ready = 1'b0; fill(9, 1);
    enable = 1'b1; out_ready = 1'b1;
    repeat (9) tick;
    chk("wrap_7", 32'(words3), 7);
    tick;
    chk("wrap_0", 32'(words3), 0);
    tick;
    chk("wrap_1", 32'(words3), 1);
    chk("wrap_w16", 32'(words16), 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
